// File: rtl/miner_test_sequencer_if.sv
// Core-array bus: broadcast work word, per-core nonce base and load strobe,
// per-core ready and nonce reporting back to the sequencer.
interface miner_test_sequencer_if #(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 256,
    parameter int NONCE_W   = 32
);
    logic [DATA_W-1:0]            core_data;
    logic [NONCE_W-1:0]           core_base;
    logic [NUM_CORES-1:0]         core_load;
    logic [NUM_CORES-1:0]         core_ready;
    logic [NUM_CORES-1:0]         core_nonce_valid;
    logic [NUM_CORES*NONCE_W-1:0] core_nonce;

    modport master (
        output core_data,
        output core_base,
        output core_load,
        input  core_ready,
        input  core_nonce_valid,
        input  core_nonce
    );

    modport slave (
        input  core_data,
        input  core_base,
        input  core_load,
        output core_ready,
        output core_nonce_valid,
        output core_nonce
    );
endinterface

// File: rtl/miner_test_sequencer.sv
// Miner test sequencer: free-running cycle counter, loads one work unit into
// each core in turn with a disjoint nonce base, then waits for a golden nonce
// or a timeout and reports core, nonce, cycle stamp and pass/fail.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start after reset
//   LOAD  | strobing core idx until its ready, then next core
//   WAIT  | all cores loaded, watching nonce_valid / timeout counter
//   DONE  | results held; start restarts the test
module miner_test_sequencer #(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 256,
    parameter int NONCE_W   = 32,
    parameter int CYCLE_W   = 32,
    parameter int TIMEOUT   = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    work_in,
    input  logic [NONCE_W-1:0]   expected_nonce,
    miner_test_sequencer_if.master core,
    output logic [CYCLE_W-1:0]   cycle,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timed_out,
    output logic [3:0]           found_core,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic [CYCLE_W-1:0]   found_cycle
);

    localparam int LOG2  = $clog2(NUM_CORES);
    localparam int IDX_W = (NUM_CORES > 1) ? LOG2 : 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [TW-1:0]      tcnt;
    logic [NONCE_W-1:0] exp_q;
    logic [3:0]         hit_idx;
    logic [NONCE_W-1:0] hit_nonce;

    // Top bits of the nonce space select the core, so bases never overlap.
    function automatic logic [NONCE_W-1:0] base_of(input logic [IDX_W-1:0] k);
        if (NUM_CORES == 1)
            return '0;
        else
            return NONCE_W'(k) << (NONCE_W - LOG2);
    endfunction

    // Lowest-index reporting core wins when several pulse together.
    always_comb begin
        hit_idx   = '0;
        hit_nonce = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (core.core_nonce_valid[k]) begin
                hit_idx   = 4'(k);
                hit_nonce = core.core_nonce[k*NONCE_W +: NONCE_W];
            end
        end
    end

    // Cycle counter plus the sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            tcnt           <= '0;
            exp_q          <= '0;
            cycle          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timed_out      <= 1'b0;
            found_core     <= '0;
            found_nonce    <= '0;
            found_cycle    <= '0;
            core.core_data <= '0;
            core.core_base <= '0;
            core.core_load <= '0;
        end else begin
            cycle <= cycle + 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        core.core_data <= work_in;
                        exp_q          <= expected_nonce;
                        pass           <= 1'b0;
                        timed_out      <= 1'b0;
                        found_core     <= '0;
                        found_nonce    <= '0;
                        found_cycle    <= '0;
                        idx            <= '0;
                        core.core_load <= NUM_CORES'(1);
                        core.core_base <= base_of('0);
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    // core_load is one-hot at idx, so this is load[idx] & ready[idx].
                    if (|(core.core_load & core.core_ready)) begin
                        if (idx == LAST_IDX) begin
                            core.core_load <= '0;
                            core.core_base <= '0;
                            tcnt           <= '0;
                            state          <= WAIT;
                        end else begin
                            idx            <= idx + 1'b1;
                            core.core_load <= core.core_load << 1;
                            core.core_base <= base_of(idx + 1'b1);
                        end
                    end
                end
                WAIT: begin
                    if (|core.core_nonce_valid) begin
                        found_core  <= hit_idx;
                        found_nonce <= hit_nonce;
                        found_cycle <= cycle;
                        pass        <= (hit_nonce == exp_q);
                        timed_out   <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (tcnt == T_LAST) begin
                        timed_out <= 1'b1;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miner_test_sequencer.sv
// Bench for miner_test_sequencer: table of full test runs (hit, priority/miss,
// timeout, valid-vs-timeout tie) plus hand sequences for backpressure, restart,
// reset mid-load and cycle wrap.
module tb_miner_test_sequencer;
    localparam int NC = 4;
    localparam int DW = 64;
    localparam int NW = 32;
    localparam int CW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] work_in = '0;
    logic [NW-1:0] expected_nonce = '0;
    logic [CW-1:0] cycle;
    logic          busy, done, pass, timed_out;
    logic [3:0]    found_core;
    logic [NW-1:0] found_nonce;
    logic [CW-1:0] found_cycle;

    miner_test_sequencer_if #(.NUM_CORES(NC), .DATA_W(DW), .NONCE_W(NW)) bus ();

    miner_test_sequencer #(
        .NUM_CORES(NC), .DATA_W(DW), .NONCE_W(NW), .CYCLE_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .work_in        (work_in),
        .expected_nonce (expected_nonce),
        .core           (bus.master),
        .cycle          (cycle),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timed_out      (timed_out),
        .found_core     (found_core),
        .found_nonce    (found_nonce),
        .found_cycle    (found_cycle)
    );

    always #5 clk = ~clk;

    // Reference cycle count: counts every rising edge, cleared by reset.
    logic [CW-1:0] mcyc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcyc <= '0;
        else        mcyc <= mcyc + 1'b1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0]    work;
        logic [NW-1:0]    expn;
        int               delay;
        logic [NC-1:0]    vmask;
        logic [NC*NW-1:0] nonces;
        logic [3:0]       ecore;
        logic [NW-1:0]    enonce;
        logic             epass;
        logic             eto;
    } vec_t;

    vec_t vecs[5];

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic do_start(input logic [DW-1:0] w, input logic [NW-1:0] e);
        start          = 1'b1;
        work_in        = w;
        expected_nonce = e;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy_done", {busy, done}, 2'b10);
        chk("restart_clear", {pass, timed_out, found_core, found_nonce, found_cycle}, '0);
        chk("core_data", bus.core_data, w);
    endtask

    task automatic load_all();
        for (int k = 0; k < NC; k++) begin
            chk("load_strobe", bus.core_load, 4'b0001 << k);
            chk("load_base", bus.core_base, 32'(k) << 30);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [CW-1:0] ecyc;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 32'h1234ABCD, 3, 4'b0100,
                    {32'h0, 32'h1234ABCD, 32'h0, 32'h0}, 4'd2, 32'h1234ABCD, 1'b1, 1'b0};
        vecs[1] = '{64'hFEDC_BA98_7654_3210, 32'h1234ABCD, 0, 4'b1010,
                    {32'h1234ABCD, 32'h0, 32'hDEADBEEF, 32'h0}, 4'd1, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{64'h1111_2222_3333_4444, 32'h0BADF00D, 0, 4'b0000,
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'd0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{64'hAAAA_5555_AAAA_5555, 32'hCAFEF00D, 7, 4'b1111,
                    {32'h3, 32'h2, 32'h1, 32'hCAFEF00D}, 4'd0, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[4] = '{64'h0000_0000_0000_0042, 32'h55AA55AA, TO - 1, 4'b1000,
                    {32'h55AA55AA, 32'h0, 32'h0, 32'h0}, 4'd3, 32'h55AA55AA, 1'b1, 1'b0};

        bus.core_ready       = 4'b1111;
        bus.core_nonce_valid = '0;
        bus.core_nonce       = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {cycle, busy, done, pass, timed_out, found_core, found_nonce,
                              found_cycle, bus.core_load, bus.core_base}, '0);
        chk("reset_core_data", bus.core_data, '0);
        rst_n = 1'b1;

        // Table-driven full runs; each later start restarts from DONE.
        for (int v = 0; v < 5; v++) begin
            do_start(vecs[v].work, vecs[v].expn);
            load_all();
            chk("wait_no_load", bus.core_load, '0);
            ecyc = '0;
            for (int w = 0; w < TO; w++) begin
                chk("wait_busy", {busy, done}, 2'b10);
                if (w == vecs[v].delay && vecs[v].vmask != '0) begin
                    bus.core_nonce_valid = vecs[v].vmask;
                    bus.core_nonce       = vecs[v].nonces;
                    ecyc                 = mcyc;
                    @(negedge clk);
                    bus.core_nonce_valid = '0;
                    break;
                end
                @(negedge clk);
            end
            chk("vec_done", {busy, done}, 2'b01);
            chk("vec_pass", pass, vecs[v].epass);
            chk("vec_timed_out", timed_out, vecs[v].eto);
            chk("vec_found_core", found_core, vecs[v].ecore);
            chk("vec_found_nonce", found_nonce, vecs[v].enonce);
            chk("vec_found_cycle", found_cycle, ecyc);
            chk("vec_cycle", cycle, mcyc);
            @(negedge clk);
            chk("done_held", {done, found_core, found_nonce}, {1'b1, vecs[v].ecore, vecs[v].enonce});
        end

        // Backpressure on core 1 for 10 cycles, nonce pulse during LOAD ignored.
        bus.core_ready = 4'b1101;
        do_start(64'h9999, 32'h77777777);
        chk("bp_load0", bus.core_load, 4'b0001);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", bus.core_load, 4'b0010);
            chk("bp_base", bus.core_base, 32'h40000000);
            if (k == 3) begin
                bus.core_nonce_valid = 4'b0001;
                bus.core_nonce       = {96'h0, 32'h77777777};
            end else begin
                bus.core_nonce_valid = '0;
            end
            @(negedge clk);
        end
        bus.core_nonce_valid = '0;
        chk("bp_hold_last", bus.core_load, 4'b0010);
        bus.core_ready = 4'b1111;
        @(negedge clk);
        chk("bp_next", bus.core_load, 4'b0100);
        @(negedge clk);
        chk("bp_last", bus.core_load, 4'b1000);
        @(negedge clk);
        for (int w = 0; w < TO; w++) begin
            chk("to_not_done", done, 1'b0);
            @(negedge clk);
        end
        chk("to_done", {busy, done, timed_out, pass}, 4'b0110);
        chk("to_no_capture", {found_core, found_nonce}, '0);

        // Reset in the middle of LOAD
        bus.core_ready = 4'b0000;
        do_start(64'h5, 32'h5);
        @(negedge clk);
        chk("mid_load", bus.core_load, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {bus.core_load, done, busy, cycle}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("cycle_after_rst", cycle, 8'(k));
            chk("idle_after_rst", {bus.core_load, busy}, '0);
        end

        // Cycle counter wrap at CYCLE_W=8
        for (int i = 0; i < 300 && mcyc != 8'hFF; i++) @(negedge clk);
        chk("cycle_ff", cycle, 8'hFF);
        @(negedge clk);
        chk("cycle_wrap", cycle, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
